// File: rtl/spi_tx_queue.sv
// SPI output driver for the display port: a small transmit FIFO that drains words
// back-to-back as SPI frames with selectable clock polarity.
module spi_tx_queue #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int FREQDIV = 25,
  parameter int CPOL    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W+1:0]        din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic [7:0]               dout
);

  localparam int   AW    = $clog2(DEPTH);
  localparam int   DIVW  = $clog2(FREQDIV);
  localparam int   BCW   = $clog2(DATA_W + 1);
  localparam logic IDLE_SCK = 1'(CPOL);

  typedef enum logic [1:0] {IDLE, START, TRANS, STOP} state_t;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic [DATA_W:0]   head;
  logic              push_ok, pop, pwr_cmd;
  logic              pmoden, vccen, res_n;

  state_t            state, state_nx;
  logic [DIVW-1:0]   div, div_nx;
  logic [BCW-1:0]    bitcnt, bitcnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              sck, sck_nx, sdo, sdo_nx, cs_n, cs_n_nx, dc_n, dc_n_nx;
  logic              div_last;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign level    = cnt;
  assign busy     = (state != IDLE) || !empty;
  assign head     = mem[rd_ptr];
  assign pwr_cmd  = wr_en && din[DATA_W+1];
  // full is taken before any same-cycle pop, so a push while full is dropped
  assign push_ok  = wr_en && !din[DATA_W+1] && !full;
  assign div_last = (div == DIVW'(FREQDIV - 1));
  assign dout     = {pmoden, vccen, res_n, dc_n, sck, 1'b0, sdo, cs_n};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din[DATA_W:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      pmoden   <= 1'b0;
      vccen    <= 1'b0;
      res_n    <= 1'b0;
    end else begin
      res_n <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (pwr_cmd) begin
        pmoden <= 1'b1;
        vccen  <= 1'b1;
      end
      if (wr_en && !din[DATA_W+1] && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      div    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      sck    <= IDLE_SCK;
      sdo    <= 1'b0;
      cs_n   <= 1'b1;
      dc_n   <= 1'b0;
    end else begin
      state  <= state_nx;
      div    <= div_nx;
      bitcnt <= bitcnt_nx;
      shreg  <= shreg_nx;
      sck    <= sck_nx;
      sdo    <= sdo_nx;
      cs_n   <= cs_n_nx;
      dc_n   <= dc_n_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    div_nx    = div + DIVW'(1);
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    sck_nx    = sck;
    sdo_nx    = sdo;
    cs_n_nx   = cs_n;
    dc_n_nx   = dc_n;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        sck_nx = IDLE_SCK;
        div_nx = '0;
        if (!empty) begin
          pop       = 1'b1;
          shreg_nx  = head[DATA_W-1:0];
          dc_n_nx   = head[DATA_W];
          cs_n_nx   = 1'b0;
          bitcnt_nx = BCW'(DATA_W);
          state_nx  = START;
        end
      end
      START: begin
        if (div_last) begin
          div_nx   = '0;
          state_nx = TRANS;
        end
      end
      TRANS: begin
        if (div_last) begin
          div_nx = '0;
          if (sck == IDLE_SCK) begin
            sck_nx    = ~IDLE_SCK;
            sdo_nx    = shreg[DATA_W-1];
            bitcnt_nx = bitcnt - BCW'(1);
          end else begin
            sck_nx   = IDLE_SCK;
            shreg_nx = shreg << 1;
            if (bitcnt == '0) state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (div_last) begin
          div_nx   = '0;
          cs_n_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: two instances (CPOL=1 and CPOL=0) share random stimulus and are
// checked against a transaction-level queue model plus a pin-level frame decoder.
module tb_spi_tx_queue;
  localparam int DW    = 8;
  localparam int DP    = 4;
  localparam int FD    = 4;
  localparam int FRAME = FD * (2 * DW + 2);

  logic          clk = 1'b0;
  logic          reset, wr_en;
  logic [DW+1:0] din;
  logic          full_1, empty_1, busy_1, ovf_1, full_0, empty_0, busy_0, ovf_0;
  logic [2:0]    level_1, level_0;
  logic [7:0]    dout_1, dout_0;

  always #5 clk = ~clk;

  spi_tx_queue #(.DATA_W(DW), .DEPTH(DP), .FREQDIV(FD), .CPOL(1)) dut_1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .full(full_1), .empty(empty_1),
    .level(level_1), .busy(busy_1), .overflow(ovf_1), .dout(dout_1));

  spi_tx_queue #(.DATA_W(DW), .DEPTH(DP), .FREQDIV(FD), .CPOL(0)) dut_0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .full(full_0), .empty(empty_0),
    .level(level_0), .busy(busy_0), .overflow(ovf_0), .dout(dout_0));

  typedef struct {
    logic          dc;
    logic [DW-1:0] pl;
    int            cyc;
  } frame_t;

  frame_t       exp_q0[$], exp_q1[$];
  logic [DW:0]  mq[$];
  int           m_left, cyc, n_cmp, n_bad;
  logic         m_ovf, m_pwr, m_res, rst_applied, mon_en;

  bit            in_fr[2];
  int            lowc[2], nb[2], lead[2];
  logic [DW-1:0] cap[2];
  logic          psck[2], pcs[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic  fullp, do_pop;
    logic [DW:0] w;
    frame_t f;
    if (reset) begin
      mq.delete(); exp_q0.delete(); exp_q1.delete();
      m_left = 0; m_ovf = 0; m_pwr = 0; m_res = 0; rst_applied = 1;
    end else begin
      rst_applied = 0;
      fullp  = (mq.size() == DP);
      do_pop = (m_left == 0) && (mq.size() > 0);
      if (m_left > 0) m_left--;
      if (do_pop) begin
        w = mq.pop_front();
        f.dc = w[DW]; f.pl = w[DW-1:0]; f.cyc = cyc;
        exp_q0.push_back(f); exp_q1.push_back(f);
        m_left = FRAME;
      end
      if (wr_en) begin
        if (din[DW+1])  m_pwr = 1;
        else if (!fullp) mq.push_back(din[DW:0]);
        else             m_ovf = 1;
      end
      m_res = 1;
    end
  endtask

  task automatic cmp_dut(input string nm, input logic [2:0] lvl, input logic fl, input logic em,
                         input logic bs, input logic ov, input logic [7:0] d, input logic cp);
    check({nm, ".level"}, lvl, mq.size());
    check({nm, ".full"}, fl, mq.size() == DP);
    check({nm, ".empty"}, em, mq.size() == 0);
    check({nm, ".busy"}, bs, (m_left > 0) || (mq.size() > 0));
    check({nm, ".overflow"}, ov, m_ovf);
    check({nm, ".pwr"}, d[7:6], {m_pwr, m_pwr});
    check({nm, ".res_"}, d[5], m_res);
    check({nm, ".cs_"}, d[0], m_left == 0);
    if (m_left == 0) check({nm, ".sck_idle"}, d[3], cp);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    cmp_dut("cpol1", level_1, full_1, empty_1, busy_1, ovf_1, dout_1, 1'b1);
    cmp_dut("cpol0", level_0, full_0, empty_0, busy_0, ovf_0, dout_0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [DW+1:0] v);
    wr_en = 1'b1; din = v;
    step();
    wr_en = 1'b0; din = '0;
  endtask

  task automatic mon(input int k, input logic [7:0] d, input logic cp);
    frame_t f;
    int     qs;
    qs = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (rst_applied) begin
      in_fr[k] = 0;
      check("mon.rst_cs", d[0], 1'b1);
      check("mon.rst_sck", d[3], cp);
    end else if (pcs[k] && !d[0]) begin
      in_fr[k] = 1; lowc[k] = 1; nb[k] = 0; lead[k] = -1; cap[k] = '0;
      check("mon.frame_expected", qs != 0, 1'b1);
      if (qs != 0) begin
        f = (k == 0) ? exp_q0[0] : exp_q1[0];
        check("mon.cs_fall_cycle", cyc, f.cyc);
        check("mon.dc", d[4], f.dc);
      end
    end else if (in_fr[k] && !d[0]) begin
      lowc[k]++;
      if (psck[k] == cp && d[3] != cp && lead[k] < 0) lead[k] = lowc[k] - 1;
      if (psck[k] != cp && d[3] == cp) begin
        cap[k] = (cap[k] << 1) | DW'(d[1]);
        nb[k]++;
      end
    end else if (in_fr[k] && d[0]) begin
      in_fr[k] = 0;
      check("mon.cs_low_cycles", lowc[k], FRAME);
      check("mon.sck_edges", nb[k], DW);
      check("mon.first_lead", lead[k], 2 * FD);
      check("mon.sck_at_rise", d[3], cp);
      if (qs != 0) begin
        f = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check("mon.payload", cap[k], f.pl);
      end
    end else if (d[0]) begin
      check("mon.idle_sck", d[3], cp);
    end
    pcs[k]  = d[0];
    psck[k] = d[3];
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon(0, dout_0, 1'b0);
        mon(1, dout_1, 1'b1);
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; din = '0;
    n_cmp = 0; n_bad = 0; cyc = 0; m_left = 0; mon_en = 0; rst_applied = 0;
    step();
    mon_en = 1;
    step(); step();
    check("rst_dout_cpol1", dout_1, 8'b0000_1001);
    check("rst_dout_cpol0", dout_0, 8'b0000_0001);
    reset = 1'b0;
    step();

    push(10'h1A5);
    idle(FRAME + 5);

    push(10'h03C);
    push(10'h0C3);
    idle(2 * FRAME + 5);

    // fill the queue, then a power command while full
    for (int i = 0; i < 5; i++) push({1'b0, 9'($urandom)});
    check("fill_level", level_1, 3'd4);
    push({1'b1, 9'($urandom)});
    check("pwr_on", dout_1[7:6], 2'b11);
    check("pwr_no_ovf", ovf_1, 1'b0);
    idle(5 * FRAME + 10);

    reset = 1'b1; step(); reset = 1'b0; step();
    for (int i = 0; i < 6; i++) push({1'b0, 9'($urandom)});
    check("ovf_set", ovf_1, 1'b1);
    idle(5 * FRAME + 10);
    check("ovf_frames_left", exp_q1.size(), 0);

    // abort a frame midway through its fourth bit
    push({1'b0, 9'($urandom)});
    idle(2 * FD + 6 * FD + 3);
    reset = 1'b1;
    step();
    check("mid_rst_dout_cpol1", dout_1, 8'b0000_1001);
    check("mid_rst_dout_cpol0", dout_0, 8'b0000_0001);
    check("mid_rst_empty", empty_1, 1'b1);
    reset = 1'b0;
    idle(FRAME + 10);

    for (int i = 0; i < 2500; i++) begin
      wr_en = ($urandom_range(0, 5) == 0);
      din   = {($urandom_range(0, 19) == 0), 9'($urandom)};
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    wr_en = 1'b0; din = '0; reset = 1'b0;
    idle(6 * FRAME);
    check("final_frames_left0", exp_q0.size(), 0);
    check("final_frames_left1", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
